// File: rtl/geo_pkg.sv
// Shared types for the geofence event tracker: fence states, event codes and the FIFO entry layout.
// Optional build macro GEO_TIMESTAMP_EN adds a cycle timestamp field to each event.
package geo_pkg;

  typedef enum logic [1:0] {
    FS_UNKNOWN = 2'd0,
    FS_OUTSIDE = 2'd1,
    FS_INSIDE  = 2'd2
  } fence_state_e;

  localparam logic EVT_EXIT  = 1'b0;
  localparam logic EVT_ENTER = 1'b1;

  // Widest supported event index; narrower CNT_W builds zero-pad the upper bits.
  localparam int EVT_IDX_W = 32;

  typedef struct packed {
    logic                 typ;
    logic [EVT_IDX_W-1:0] index;
`ifdef GEO_TIMESTAMP_EN
    logic [31:0]          tstamp;
`endif
  } geo_evt_t;

endpackage

// File: rtl/geo_evt_fifo.sv
// First-word fall-through FIFO with registered storage; head entry is always visible on o_data.
// Push while full is accepted only when a pop happens in the same cycle.
module geo_evt_fifo #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/geo_event_tracker.sv
// Debounces geofence verdicts into ENTER/EXIT events, counts results and queues events for a consumer.
// Define GEO_TIMESTAMP_EN to stamp each event with a free-running 32-bit cycle count (adds evt_time).
module geo_event_tracker
  import geo_pkg::*;
#(
  parameter int DEBOUNCE   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic             is_inside,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_type,
  output logic [CNT_W-1:0] evt_index,
`ifdef GEO_TIMESTAMP_EN
  output logic [31:0]      evt_time,
`endif
  output logic [1:0]       fence_state,
  output logic [CNT_W-1:0] inside_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             overflow
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  fence_state_e     r_state;
  fence_state_e     w_state_nxt;
  logic [3:0]       r_run;
  logic [3:0]       w_run_nxt;
  logic [3:0]       w_run_inc;
  logic             w_opp;
  logic             w_push;
  logic             w_push_type;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] r_inside_cnt;
  logic [CNT_W-1:0] r_total_cnt;
  logic             r_overflow;
  geo_evt_t         w_evt;
  geo_evt_t         w_head;
`ifdef GEO_TIMESTAMP_EN
  logic [31:0]      r_cycle;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_run_inc = r_run + 4'd1;
  assign w_opp     = (r_state == FS_INSIDE) ? !is_inside : is_inside;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_push      = 1'b0;
    w_push_type = EVT_EXIT;
    if (res_valid) begin
      case (r_state)
        FS_UNKNOWN: begin
          w_state_nxt = is_inside ? FS_INSIDE : FS_OUTSIDE;
          w_run_nxt   = 4'd0;
        end
        FS_OUTSIDE, FS_INSIDE: begin
          if (!w_opp) begin
            w_run_nxt = 4'd0;
          end else if (w_run_inc == DEB) begin
            w_state_nxt = is_inside ? FS_INSIDE : FS_OUTSIDE;
            w_run_nxt   = 4'd0;
            w_push      = 1'b1;
            w_push_type = is_inside ? EVT_ENTER : EVT_EXIT;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end
        default: begin
          w_state_nxt = FS_UNKNOWN;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FS_UNKNOWN;
      r_run        <= 4'd0;
      r_inside_cnt <= '0;
      r_total_cnt  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      if (res_valid) begin
        r_total_cnt <= sat_inc(r_total_cnt);
        if (is_inside) r_inside_cnt <= sat_inc(r_inside_cnt);
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef GEO_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end
`endif

  // The event index is the pre-increment (already saturated) result count.
  always_comb begin
    w_evt                   = '0;
    w_evt.typ               = w_push_type;
    w_evt.index[CNT_W-1:0]  = r_total_cnt;
`ifdef GEO_TIMESTAMP_EN
    w_evt.tstamp            = r_cycle;
`endif
  end

  assign w_pop = evt_valid && evt_ready;

  geo_evt_fifo #(
    .DATA_W ($bits(geo_evt_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  if (CNT_W < EVT_IDX_W) begin : g_idx_pad
    logic w_idx_unused;
    assign w_idx_unused = ^w_head.index[EVT_IDX_W-1:CNT_W];
  end

  assign evt_valid   = !w_empty;
  assign evt_type    = w_head.typ;
  assign evt_index   = w_head.index[CNT_W-1:0];
`ifdef GEO_TIMESTAMP_EN
  assign evt_time    = w_head.tstamp;
`endif
  assign fence_state = r_state;
  assign inside_cnt  = r_inside_cnt;
  assign total_cnt   = r_total_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_geo_event_tracker.sv
// Directed scoreboard bench for geo_event_tracker (DEBOUNCE=2, FIFO_DEPTH=4, CNT_W=16).
module tb_geo_event_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        is_inside;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_type;
  logic [15:0] evt_index;
  logic [1:0]  fence_state;
  logic [15:0] inside_cnt;
  logic [15:0] total_cnt;
  logic        overflow;
`ifdef GEO_TIMESTAMP_EN
  logic [31:0] evt_time;
`endif

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  geo_event_tracker #(
    .DEBOUNCE   (2),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .res_valid   (res_valid),
    .is_inside   (is_inside),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_index   (evt_index),
`ifdef GEO_TIMESTAMP_EN
    .evt_time    (evt_time),
`endif
    .fence_state (fence_state),
    .inside_cnt  (inside_cnt),
    .total_cnt   (total_cnt),
    .overflow    (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL evt_unexpected: got type=%0d index=%0d, expected no event", evt_type, evt_index);
      end else begin
        chk("evt_type_index", {15'd0, evt_type, evt_index}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic exp_evt(input logic t, input int idx);
    exp_q.push_back({t, 16'(idx)});
  endtask

  task automatic vd(input logic b);
    res_valid = 1'b1;
    is_inside = b;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    res_valid = 1'b0;
    is_inside = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_left", exp_q.size(), 0);
    chk("drain_evt_valid", evt_valid, 0);
  endtask

  // Four events with ready low: ENTER@2, EXIT@4, ENTER@6, EXIT@8; ends OUTSIDE.
  task automatic fill_four();
    vd(0); vd(1);
    exp_evt(1, 2); vd(1);
    vd(0);
    exp_evt(0, 4); vd(0);
    vd(1);
    exp_evt(1, 6); vd(1);
    vd(0);
    exp_evt(0, 8); vd(0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; res_valid = 1'b0; is_inside = 1'b0; evt_ready = 1'b1;
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_type", evt_type, 0);
    chk("rst_evt_index", evt_index, 0);
    chk("rst_fence_state", fence_state, 0);
    chk("rst_inside_cnt", inside_cnt, 0);
    chk("rst_total_cnt", total_cnt, 0);
    chk("rst_overflow", overflow, 0);

    // 1,1,1: INSIDE after first, no events
    do_reset();
    vd(1);
    chk("t1_state_first", fence_state, 2);
    vd(1); vd(1);
    chk("t1_inside_cnt", inside_cnt, 3);
    chk("t1_total_cnt", total_cnt, 3);
    chk("t1_no_evt", evt_valid, 0);

    // 0,1,0,0: OUTSIDE, lone 1 does not switch
    do_reset();
    vd(0); vd(1); vd(0); vd(0);
    chk("t2_state", fence_state, 1);
    chk("t2_inside_cnt", inside_cnt, 1);
    chk("t2_total_cnt", total_cnt, 4);
    chk("t2_no_evt", evt_valid, 0);

    // 0,1,1,0,0 with ready: ENTER@2, EXIT@4, each visible one cycle after
    do_reset();
    vd(0); vd(1);
    chk("t3_before_enter", evt_valid, 0);
    exp_evt(1, 2); vd(1);
    chk("t3_enter_latency", evt_valid, 1);
    chk("t3_state_inside", fence_state, 2);
    vd(0);
    exp_evt(0, 4); vd(0);
    chk("t3_exit_latency", evt_valid, 1);
    idle(2);
    chk("t3_queue_left", exp_q.size(), 0);
    chk("t3_evt_idle", evt_valid, 0);

    // Overflow: fifth event dropped while consumer stalls
    do_reset();
    evt_ready = 1'b0;
    fill_four();
    chk("t4_overflow_before", overflow, 0);
    vd(1); vd(1);
    chk("t4_overflow_after", overflow, 1);
    chk("t4_state_still_updates", fence_state, 2);
    chk("t4_total_still_counts", total_cnt, 11);
    drain();
    chk("t4_overflow_sticky", overflow, 1);

    // Full FIFO with pop coinciding with push: no drop, still full afterwards
    do_reset();
    evt_ready = 1'b0;
    fill_four();
    vd(1);
    exp_evt(1, 10);
    evt_ready = 1'b1;
    vd(1);
    evt_ready = 1'b0;
    chk("t5_no_overflow", overflow, 0);
    vd(0); vd(0);
    chk("t5_full_again_drops", overflow, 1);
    drain();

    // Reset mid-operation with 2 queued events and run=1
    do_reset();
    evt_ready = 1'b0;
    vd(0); vd(1);
    exp_evt(1, 2); vd(1);
    vd(0);
    exp_evt(0, 4); vd(0);
    vd(1);
    chk("t6_queued_before", evt_valid, 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_evt_valid", evt_valid, 0);
    chk("t6_rst_total", total_cnt, 0);
    chk("t6_rst_inside", inside_cnt, 0);
    chk("t6_rst_state", fence_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    evt_ready = 1'b1;
    vd(1);
    chk("t6_reenter_state", fence_state, 2);
    chk("t6_reenter_total", total_cnt, 1);
    idle(2);
    chk("t6_no_evt", evt_valid, 0);
    chk("t6_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/geo_event_tracker.md
Name: geo_event_tracker

Overview:
- Sits directly downstream of the geofence judge stage; samples its one-cycle valid pulse and is_inside verdict.
- Debounces successive verdicts into ENTER/EXIT events and keeps inside/total result counters.
- Buffers events in a small FIFO drained by a valid/ready consumer, such as a host register block or log writer.

Parameters:
DEBOUNCE, 2, consecutive opposing verdicts needed to change fence state (legal 1..15)
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)
CNT_W, 16, width of counters and event index

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
res_valid  in  1  one-cycle pulse: verdict present on is_inside
is_inside  in  1  1 = target inside polygon; sampled only when res_valid=1
evt_valid  out  1  FIFO head event available
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready at clock edge
evt_type  out  1  1 = ENTER, 0 = EXIT
evt_index  out  CNT_W  0-based result number that triggered the event
fence_state  out  2  current FSM state encoding
inside_cnt  out  CNT_W  number of inside verdicts, saturating
total_cnt  out  CNT_W  number of verdicts, saturating
overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high, port name reset. All outputs are registered.
- Reset values: evt_valid=0, evt_type=0, evt_index=0, fence_state=UNKNOWN(0), inside_cnt=0, total_cnt=0, overflow=0. FIFO empty, run counter 0.
- Reset asserted mid-operation: discards the FIFO contents and all state immediately.
- FSM states: UNKNOWN=0, OUTSIDE=1, INSIDE=2. A 4-bit run counter holds consecutive opposing verdicts.
- UNKNOWN: the first res_valid moves to INSIDE or OUTSIDE per is_inside. No event. Run counter = 0.
- OUTSIDE/INSIDE, on res_valid:
  - Verdict agrees with state: run counter cleared.
  - Verdict opposes state: run+1.
  - If run+1 == DEBOUNCE: switch state, clear run, push event (ENTER when going to INSIDE, EXIT when going to OUTSIDE). evt_index = total_cnt before increment.
- Counters, on each res_valid: total_cnt+1, and inside_cnt+1 if is_inside. Each saturates at all-ones independently. The event index uses the saturated value.
- Latency: a res_valid at edge t pushes at edge t. evt_valid is high after edge t if the FIFO was empty, i.e. the event is visible in the cycle following the verdict.
- FIFO: first-word fall-through from registered storage. evt_type and evt_index always show the head entry; their value is don't-care while evt_valid=0.
- Full FIFO plus a push without a pop in the same cycle: the event is dropped, overflow=1, state and counters still update.
- Full FIFO plus simultaneous push and pop: both happen, no drop.
- Empty FIFO plus push: the pop is not possible in the same cycle.
- overflow clears only on reset.
- res_valid is never high in consecutive cycles from the geofence. The tracker must still handle back-to-back pulses correctly.

Optional Feature:
- Macro GEO_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, that wraps.
  - Each FIFO entry stores the counter value at push.
  - Adds output port evt_time [31:0] alongside evt_index.
- Undefined: no counter, no storage, no port.

Decomposition:
- Package geo_pkg holds:
  - fence-state enum (UNKNOWN, OUTSIDE, INSIDE)
  - event-type constants (EVT_EXIT=0, EVT_ENTER=1)
  - event struct {type, index[, time]}
- Sub-module geo_evt_fifo: parameterised synchronous FWFT FIFO with push/pop/full/empty, instanced once.
- FSM and counters live in the top.

Test Plan:
- Reset then verdicts 1,1,1 (DEBOUNCE=2) -> state INSIDE after the first, no event, inside_cnt=3, total_cnt=3.
- Verdicts 0,1,0,0 -> UNKNOWN->OUTSIDE; the single 1 does not switch; the final 0,0 keep OUTSIDE. No events; inside_cnt=1, total_cnt=4.
- Verdicts 0,1,1,0,0 with evt_ready=1 -> ENTER at index 2, then EXIT at index 4. Each evt_valid appears one cycle after its verdict.
- evt_ready=0, DEBOUNCE=1, alternating verdicts 0,1,0,1,0,1 -> 4 events stored (indices 1..4), fifth dropped, overflow=1. Draining returns indices 1,2,3,4 in order.
- FIFO full with evt_ready=1 in the same cycle as an event-producing verdict -> no drop, overflow stays 0, occupancy stays 4.
- Assert reset while 2 events are queued and run=1 -> evt_valid=0 and counters=0 immediately. The next verdict re-enters via UNKNOWN with no event.
